// File: rtl/boxcar_decimator.sv
// -----------------------------------------------------------------------------
// boxcar_decimator
//
// Downsampling stage. Accepts a valid/ready sample stream and emits one
// sample for every block of 2**FACTOR_LOG2 accepted inputs. With AVG=1 the
// emitted sample is the floor of the block average (boxcar filter followed by
// decimation); with AVG=0 it is the first sample of the block.
//
// Parameters:
//   DATA_W       unsigned sample width
//   FACTOR_LOG2  log2 of the decimation factor, legal range 1..8
//   AVG          1 = block average, 0 = first sample of block
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   upstream sample present
//   in_ready   out  block can accept a sample this cycle (combinational)
//   in_data    in   upstream sample, DATA_W bits
//   out_valid  out  decimated sample present (registered)
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  decimated sample, DATA_W bits (registered)
// -----------------------------------------------------------------------------

// Elaboration-time configuration check for the decimator.
module boxcar_decimator_cfg_chk #(
    parameter int FACTOR_LOG2 = 2
) ();
    generate
        if ((FACTOR_LOG2 < 1) || (FACTOR_LOG2 > 8)) begin : g_bad_factor
            $error("boxcar_decimator: FACTOR_LOG2=%0d outside legal range 1..8", FACTOR_LOG2);
        end
    endgenerate
endmodule

module boxcar_decimator #(
    parameter int DATA_W      = 8,
    parameter int FACTOR_LOG2 = 2,
    parameter int AVG         = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    // Accumulator carries FACTOR_LOG2 extra bits so a full block of
    // maximum-valued samples cannot overflow it.
    localparam int ACC_W = DATA_W + FACTOR_LOG2;

    logic [FACTOR_LOG2-1:0] phase_r;
    logic [ACC_W-1:0]       acc_r;
    logic [DATA_W-1:0]      first_r;
    logic                   out_valid_r;
    logic [DATA_W-1:0]      out_data_r;

    logic                   last_phase_s;
    logic                   first_phase_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   complete_s;
    logic                   transfer_s;
    logic [ACC_W-1:0]       sum_s;
    logic [DATA_W-1:0]      result_s;

    boxcar_decimator_cfg_chk #(
        .FACTOR_LOG2(FACTOR_LOG2)
    ) u_cfg_chk ();

    // Handshake decode and block-result computation.
    always_comb begin
        last_phase_s  = 1'b0;
        first_phase_s = 1'b0;
        in_ready_s    = 1'b0;
        accept_s      = 1'b0;
        complete_s    = 1'b0;
        transfer_s    = 1'b0;
        sum_s         = {ACC_W{1'b0}};
        result_s      = {DATA_W{1'b0}};

        last_phase_s  = (phase_r == {FACTOR_LOG2{1'b1}});
        first_phase_s = (phase_r == {FACTOR_LOG2{1'b0}});

        // Only the block-completing sample is held off while the output
        // register is occupied and stalled; partial accumulation continues.
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !(last_phase_s && out_valid_r && !out_ready);
        end

        accept_s   = in_valid && in_ready_s;
        complete_s = accept_s && last_phase_s;
        transfer_s = out_valid_r && out_ready;

        sum_s = acc_r + {{FACTOR_LOG2{1'b0}}, in_data};

        // Upper DATA_W bits of the sum are the floor of sum / FACTOR.
        if (AVG != 0) begin
            result_s = sum_s[ACC_W-1:FACTOR_LOG2];
        end else begin
            result_s = first_r;
        end
    end

    // Block accumulation: phase counter, running sum and first sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= {FACTOR_LOG2{1'b0}};
            acc_r   <= {ACC_W{1'b0}};
            first_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            if (last_phase_s) begin
                phase_r <= {FACTOR_LOG2{1'b0}};
                acc_r   <= {ACC_W{1'b0}};
                first_r <= first_r;
            end else begin
                phase_r <= phase_r + FACTOR_LOG2'(1);
                acc_r   <= sum_s;
                if (first_phase_s) begin
                    first_r <= in_data;
                end else begin
                    first_r <= first_r;
                end
            end
        end else begin
            phase_r <= phase_r;
            acc_r   <= acc_r;
            first_r <= first_r;
        end
    end

    // Single-entry output register. A completion in the same cycle as a
    // transfer reloads the register and keeps out_valid high (no bubble).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else if (complete_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
        end else if (transfer_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule
